// File: rtl/xadac_vrf_sb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xadac_vrf_sb_pkg
// Brief    : Shared types for the vector-register scoreboard (xadac_vrf_sb).
// Revision : 1.0
// ============================================================================
package xadac_vrf_sb_pkg;

  // Number of vector source operands carried by an execute request
  localparam int NoVs        = 3;
  localparam int NoRegsDef   = 32;
  localparam int MaxPendDef  = 3;

  typedef logic [$clog2(NoRegsDef)-1:0]    VecAddrT;
  typedef logic [$clog2(MaxPendDef+1)-1:0] SbCntT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } SbStateT;

endpackage : xadac_vrf_sb_pkg
`default_nettype wire

// File: rtl/xadac_vrf_sb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : xadac_vrf_sb_cnt
// Brief    : Saturating up/down outstanding-write counter for one register.
// Revision : 1.0
// ============================================================================
module xadac_vrf_sb_cnt #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = $clog2(MAX_PEND+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_full,
  output logic o_underflow
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_PEND);

  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;
  logic             w_full;

  assign w_zero = (r_cnt == '0);
  assign w_full = (r_cnt == c_max);

  // A simultaneous inc and dec cancel; saturation guards both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero      = w_zero;
  assign o_full      = w_full;
  assign o_underflow = i_dec && w_zero;

endmodule : xadac_vrf_sb_cnt
`default_nettype wire

// File: rtl/xadac_vrf_sb.sv
`default_nettype none
// ============================================================================
// Module   : xadac_vrf_sb
// Brief    : Vector-register scoreboard / issue gate with drain sequencer.
//            XADAC_VRF_SB_WAW_EN: stall any write to a register still pending.
// Revision : 1.0
// ============================================================================
module xadac_vrf_sb
  import xadac_vrf_sb_pkg::*;
#(
  parameter int NoRegs  = 32,
  parameter int MaxPend = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [NoVs-1:0][$clog2(NoRegs)-1:0]  issue_vs_addr,
  input  logic [NoVs-1:0]                      issue_vs_use,
  input  logic [$clog2(NoRegs)-1:0]            issue_vd_addr,
  input  logic                                 issue_vd_write,
  output logic                                 fwd_valid,
  input  logic                                 fwd_ready,
  input  logic                                 wb_valid,
  input  logic                                 wb_ready,
  input  logic [$clog2(NoRegs)-1:0]            wb_vd_addr,
  input  logic                                 wb_vd_write,
  input  logic                                 drain_req,
  output logic                                 drain_ack,
  output logic [NoRegs-1:0]                    pend_mask,
  output logic                                 busy,
  output logic                                 err
);

  localparam int c_aw = $clog2(NoRegs);

  SbStateT           r_state;
  SbStateT           w_state_nxt;
  logic              r_err;
  logic [NoRegs-1:0] w_zero;
  logic [NoRegs-1:0] w_full;
  logic [NoRegs-1:0] w_underflow;
  logic [NoRegs-1:0] w_inc;
  logic [NoRegs-1:0] w_dec;
  logic              w_raw;
  logic              w_dst;
  logic              w_hazard;
  logic              w_fire;
  logic              w_retire;
  logic              w_all_zero;

  assign w_fire     = issue_valid && issue_ready;
  assign w_retire   = wb_valid && wb_ready && wb_vd_write;
  assign w_all_zero = &w_zero;

  generate
    for (genvar r = 0; r < NoRegs; r++) begin : g_cnt
      assign w_inc[r] = w_fire && issue_vd_write && (issue_vd_addr == c_aw'(r));
      assign w_dec[r] = w_retire && (wb_vd_addr == c_aw'(r));

      xadac_vrf_sb_cnt #(
        .MAX_PEND (MaxPend)
      ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_inc[r]),
        .i_dec       (w_dec[r]),
        .o_zero      (w_zero[r]),
        .o_full      (w_full[r]),
        .o_underflow (w_underflow[r])
      );
    end
  endgenerate

  // Hazards look only at registered counts: a retire this cycle frees its
  // register for consumers starting next cycle.
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < NoVs; i++) begin
      if (issue_vs_use[i] && !w_zero[issue_vs_addr[i]]) begin
        w_raw = 1'b1;
      end
    end
  end

`ifdef XADAC_VRF_SB_WAW_EN
  assign w_dst = issue_vd_write && (!w_zero[issue_vd_addr] || w_full[issue_vd_addr]);
`else
  assign w_dst = issue_vd_write && w_full[issue_vd_addr];
`endif

  assign w_hazard    = w_raw || w_dst || (r_state != IDLE);
  assign fwd_valid   = issue_valid && !w_hazard;
  assign issue_ready = fwd_ready && !w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (drain_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!drain_req)      w_state_nxt = IDLE;
        else if (w_all_zero) w_state_nxt = DONE;
      end
      DONE: begin
        if (!drain_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sticky until reset: a writeback with nothing outstanding for its register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (|w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign drain_ack = (r_state == DONE);
  assign pend_mask = ~w_zero;
  assign busy      = ~w_all_zero;
  assign err       = r_err;

endmodule : xadac_vrf_sb
`default_nettype wire

// File: tb/tb_xadac_vrf_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_xadac_vrf_sb
// Brief    : Self-checking bench for xadac_vrf_sb (vector table, corner
//            sequences, randomized run against a reference model).
// Revision : 1.0
// ============================================================================
module tb_xadac_vrf_sb;
  import xadac_vrf_sb_pkg::*;

`ifdef XADAC_VRF_SB_WAW_EN
  localparam int c_lim = 1;
`else
  localparam int c_lim = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [NoVs-1:0][4:0] issue_vs_addr;
  logic [NoVs-1:0]      issue_vs_use;
  logic [4:0]           issue_vd_addr;
  logic                 issue_vd_write;
  logic                 fwd_valid;
  logic                 fwd_ready;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [4:0]           wb_vd_addr;
  logic                 wb_vd_write;
  logic                 drain_req;
  logic                 drain_ack;
  logic [31:0]          pend_mask;
  logic                 busy;
  logic                 err;

  int n_checks = 0;
  int n_errors = 0;

  xadac_vrf_sb #(.NoRegs(32), .MaxPend(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vs_addr(issue_vs_addr), .issue_vs_use(issue_vs_use),
    .issue_vd_addr(issue_vd_addr), .issue_vd_write(issue_vd_write),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_vd_addr(wb_vd_addr), .wb_vd_write(wb_vd_write),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .pend_mask(pend_mask), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid = 0; issue_vs_use = '0; issue_vs_addr = '0;
    issue_vd_addr = 0; issue_vd_write = 0; fwd_ready = 1;
    wb_valid = 0; wb_ready = 0; wb_vd_addr = 0; wb_vd_write = 0;
  endtask

  task automatic retire(input int a);
    wb_valid = 1; wb_ready = 1; wb_vd_write = 1; wb_vd_addr = 5'(a);
  endtask

  task automatic wb_off();
    wb_valid = 0; wb_ready = 0; wb_vd_write = 0;
  endtask

  task automatic issue_wr(input int a);
    issue_valid = 1; issue_vd_write = 1; issue_vd_addr = 5'(a);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_pend_mask", pend_mask, 0);
    check("rst_err", 32'(err), 0);
    check("rst_drain_ack", 32'(drain_ack), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    rst = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int iv, vs_use, vs, vd, vw, fr, wv, wr, wa, ww, dr;
    int fv, ir, pm, er, ack;
  } vec_t;
  vec_t vecs[$];

  // ---------------- reference model ----------------
  int m_cnt[32];
  bit m_err;
  int m_st;  // 0 idle, 1 draining, 2 drained

  function automatic void m_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0;
    m_st  = 0;
  endfunction

  function automatic bit m_hazard();
    bit h = (m_st != 0);
    for (int i = 0; i < NoVs; i++)
      if (issue_vs_use[i] && m_cnt[issue_vs_addr[i]] != 0) h = 1;
    if (issue_vd_write && m_cnt[issue_vd_addr] >= c_lim) h = 1;
    return h;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int r = 0; r < 32; r++) m[r] = (m_cnt[r] != 0);
    return m;
  endfunction

  function automatic void m_step();
    bit fire   = issue_valid && fwd_ready && !m_hazard();
    bit inc    = fire && issue_vd_write;
    bit dec    = wb_valid && wb_ready && wb_vd_write;
    bit allz   = (m_mask() == 0);
    if (dec && m_cnt[wb_vd_addr] == 0) m_err = 1;
    if (!(inc && dec && issue_vd_addr == wb_vd_addr)) begin
      if (inc) m_cnt[issue_vd_addr]++;
      if (dec && m_cnt[wb_vd_addr] > 0) m_cnt[wb_vd_addr]--;
    end
    case (m_st)
      0: if (drain_req) m_st = 1;
      1: if (!drain_req) m_st = 0; else if (allz) m_st = 2;
      default: if (!drain_req) m_st = 0;
    endcase
  endfunction

  initial begin
    rst = 1;
    drain_req = 0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // iv use vs vd vw fr wv wr wa ww dr | fv ir pm er ack
    vecs.push_back('{0,0, 0, 0,0,1,0,0, 0,0,0, 0,0+1,0,0,0});
    vecs.push_back('{1,0, 0, 3,1,1,0,0, 0,0,0, 1,1,0,0,0});
    vecs.push_back('{1,1, 3, 0,0,1,0,0, 0,0,0, 0,0,1<<3,0,0});
    vecs.push_back('{1,1, 3, 0,0,1,1,1, 3,1,0, 0,0,1<<3,0,0});
    vecs.push_back('{1,1, 3, 0,0,1,0,0, 0,0,0, 1,1,0,0,0});
    vecs.push_back('{1,0, 0,10,1,0,0,0, 0,0,0, 1,0,0,0,0});
    vecs.push_back('{1,0, 0,10,1,1,0,0, 0,0,0, 1,1,0,0,0});
    vecs.push_back('{1,0,10, 0,0,1,0,0, 0,0,0, 1,1,1<<10,0,0});
    vecs.push_back('{1,4,10, 0,0,1,0,0, 0,0,0, 0,0,1<<10,0,0});
    vecs.push_back('{1,4,10, 0,0,1,1,0,10,1,0, 0,0,1<<10,0,0});
    vecs.push_back('{1,4,10, 0,0,1,1,1,10,0,0, 0,0,1<<10,0,0});
    vecs.push_back('{1,4,10, 0,0,1,1,1,10,1,0, 0,0,1<<10,0,0});
    vecs.push_back('{0,0, 0, 0,0,1,0,0, 0,0,0, 0,1,0,0,0});
    vecs.push_back('{0,0, 0, 0,0,1,1,1, 9,1,0, 0,1,0,0,0});
    vecs.push_back('{0,0, 0, 0,0,1,0,0, 0,0,0, 0,1,0,1,0});
    vecs.push_back('{0,0, 0, 0,0,1,0,0, 0,0,0, 0,1,0,1,0});

    for (int k = 0; k < vecs.size(); k++) begin
      issue_valid    = vecs[k].iv[0];
      issue_vs_use   = 3'(vecs[k].vs_use);
      for (int i = 0; i < NoVs; i++) issue_vs_addr[i] = 5'(vecs[k].vs);
      issue_vd_addr  = 5'(vecs[k].vd);
      issue_vd_write = vecs[k].vw[0];
      fwd_ready      = vecs[k].fr[0];
      wb_valid       = vecs[k].wv[0];
      wb_ready       = vecs[k].wr[0];
      wb_vd_addr     = 5'(vecs[k].wa);
      wb_vd_write    = vecs[k].ww[0];
      drain_req      = vecs[k].dr[0];
      #1;
      check($sformatf("vec%0d_fwd_valid", k), 32'(fwd_valid), 32'(vecs[k].fv));
      check($sformatf("vec%0d_issue_ready", k), 32'(issue_ready), 32'(vecs[k].ir));
      check($sformatf("vec%0d_pend_mask", k), pend_mask, 32'(vecs[k].pm));
      check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].pm != 0));
      check($sformatf("vec%0d_err", k), 32'(err), 32'(vecs[k].er));
      check($sformatf("vec%0d_drain_ack", k), 32'(drain_ack), 32'(vecs[k].ack));
      tick();
    end
    idle_in();
    do_reset();  // err must clear here

`ifndef XADAC_VRF_SB_WAW_EN
    // Overflow: fourth write to v7 held until one retire
    issue_wr(7);
    for (int k = 0; k < 3; k++) begin
      #1; check("ovf_accept", 32'(issue_ready), 1);
      tick();
    end
    #1; check("ovf_held_ready", 32'(issue_ready), 0);
    check("ovf_held_fwd", 32'(fwd_valid), 0);
    tick();
    retire(7);
    #1; check("ovf_retire_cycle_ready", 32'(issue_ready), 0);
    tick();
    wb_off();
    #1; check("ovf_release_ready", 32'(issue_ready), 1);
    check("ovf_release_fwd", 32'(fwd_valid), 1);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      retire(7); tick();
    end
    wb_off();
    #1; check("ovf_cleared", pend_mask, 0);
    check("ovf_err", 32'(err), 0);

    // Simultaneous issue-write and retire on v5 with cnt = 1
    issue_wr(5); tick();
    issue_wr(5); retire(5);
    #1; check("sim_ready", 32'(issue_ready), 1);
    tick();
    idle_in();
    #1; check("sim_pend5", 32'(pend_mask[5]), 1);
    retire(5); tick();
    wb_off();
    #1; check("sim_single_retire_clears", pend_mask, 0);
    check("sim_err", 32'(err), 0);
`else
    // WAW: second write to v2 held until v2 retires
    issue_wr(2);
    #1; check("waw_first", 32'(issue_ready), 1);
    tick();
    #1; check("waw_held_ready", 32'(issue_ready), 0);
    check("waw_held_fwd", 32'(fwd_valid), 0);
    retire(2);
    #1; check("waw_retire_cycle", 32'(issue_ready), 0);
    tick();
    wb_off();
    #1; check("waw_release", 32'(fwd_valid), 1);
    tick();
    idle_in(); retire(2); tick();
    wb_off();
    #1; check("waw_cleared", pend_mask, 0);
`endif

    // Drain with two writes in flight
    idle_in();
    issue_wr(1); tick();
    issue_wr(4); tick();
    idle_in();
    drain_req = 1;
    #1; check("drn_ack_start", 32'(drain_ack), 0);
    tick();
    issue_wr(20);
    #1; check("drn_blocked_fwd", 32'(fwd_valid), 0);
    check("drn_blocked_ready", 32'(issue_ready), 0);
    tick();
    retire(1);
    #1; check("drn_ack_pending", 32'(drain_ack), 0);
    tick();
    retire(4); tick();
    wb_off();
    #1; check("drn_ack_not_yet", 32'(drain_ack), 0);
    check("drn_mask_zero", pend_mask, 0);
    tick();
    #1; check("drn_ack_high", 32'(drain_ack), 1);
    check("drn_done_blocked", 32'(fwd_valid), 0);
    drain_req = 0;
    tick();
    #1; check("drn_ack_dropped", 32'(drain_ack), 0);
    check("drn_resume_fwd", 32'(fwd_valid), 1);
    check("drn_resume_ready", 32'(issue_ready), 1);
    idle_in();

    // Drain with counts already zero: ack two cycles after request
    drain_req = 1;
    #1; check("drz_c0", 32'(drain_ack), 0);
    tick();
    #1; check("drz_c1", 32'(drain_ack), 0);
    tick();
    #1; check("drz_c2", 32'(drain_ack), 1);
    drain_req = 0;
    tick();
    #1; check("drz_idle", 32'(drain_ack), 0);

    // Randomized run against the reference model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 300 == 299) begin
        rst = 1; #1; m_reset(); tick(); rst = 0;
      end
      issue_valid    = ($urandom % 4) != 0;
      for (int i = 0; i < NoVs; i++) issue_vs_addr[i] = 5'($urandom % 8);
      issue_vs_use   = 3'($urandom);
      issue_vd_addr  = 5'($urandom % 8);
      issue_vd_write = ($urandom % 4) != 0;
      fwd_ready      = ($urandom % 4) != 0;
      wb_valid       = ($urandom % 5) < 2;
      wb_ready       = ($urandom % 4) != 0;
      wb_vd_addr     = 5'($urandom % 8);
      wb_vd_write    = ($urandom % 8) != 0;
      if (($urandom % 40) == 0) drain_req = ~drain_req;
      #1;
      check("rnd_fwd_valid", 32'(fwd_valid), 32'(issue_valid && !m_hazard()));
      check("rnd_issue_ready", 32'(issue_ready), 32'(fwd_ready && !m_hazard()));
      check("rnd_pend_mask", pend_mask, m_mask());
      check("rnd_busy", 32'(busy), 32'(m_mask() != 0));
      check("rnd_drain_ack", 32'(drain_ack), 32'(m_st == 2));
      check("rnd_err", 32'(err), 32'(m_err));
      m_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_xadac_vrf_sb
`default_nettype wire

// File: doc/xadac_vrf_sb.md
# xadac_vrf_sb

Vector-register scoreboard and issue controller placed in front of `xadac_vrf`. It tracks vector registers with outstanding writes and holds back any execute request whose sources (RAW) or destination (overflow/WAW) conflict with them. It retires entries when the downstream `exe_rsp` handshake writes back. It also provides a drain sequencer that blocks issue until all in-flight writes have retired.

## Interface
Parameters:
- `NoRegs`, 32, number of architectural vector registers; the address width is `$clog2(NoRegs)`, which matches `VecAddrT`.
- `MaxPend`, 3, maximum number of outstanding writes tracked per register (≥1).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  upstream execute request valid.
- `issue_ready`  out  1  upstream request accepted.
- `issue_vs_addr`  in  NoVs×VecAddrT  source register addresses.
- `issue_vs_use`  in  NoVs  per-source "operand is read" flag.
- `issue_vd_addr`  in  VecAddrT  destination register.
- `issue_vd_write`  in  1  instruction writes `issue_vd_addr`.
- `fwd_valid`  out  1  request forwarded to `xadac_vrf` exe slave.
- `fwd_ready`  in  1  downstream exe ready.
- `wb_valid`  in  1  copy of the `exe_rsp` valid.
- `wb_ready`  in  1  copy of the `exe_rsp` ready.
- `wb_vd_addr`  in  VecAddrT  writeback register.
- `wb_vd_write`  in  1  writeback actually writes.
- `drain_req`  in  1  request to quiesce.
- `drain_ack`  out  1  no writes in flight and issue is blocked.
- `pend_mask`  out  NoRegs  bit r is set while `cnt[r]` ≠ 0.
- `busy`  out  1  OR of `pend_mask`.
- `err`  out  1  sticky flag: writeback arrived for a register with `cnt` = 0.

## Operation
- **Per-register counter.** Each register r has a counter `cnt[r]` of width `$clog2(MaxPend+1)`, reset to 0.
- **Issue fire:** `issue_valid && issue_ready`. When `issue_vd_write` is set, `cnt[issue_vd_addr]` increments.
- **Retire:** `wb_valid && wb_ready && wb_vd_write`. This decrements `cnt[wb_vd_addr]`.
- **Same register, same cycle:** if issue fire and retire target the same register, `cnt` is unchanged.
- **Underflow:** a retire when `cnt` = 0 leaves `cnt` at 0 and sets `err`. `err` is cleared only by reset.
- **Hazard** is computed from registered counts only; there is no same-cycle bypass. A hazard exists when any of these holds:
  - RAW: for some i, `issue_vs_use[i]` is set and `cnt[issue_vs_addr[i]]` ≠ 0.
  - Overflow: `issue_vd_write` is set and `cnt[issue_vd_addr]` = MaxPend.
  - Blocked: the FSM is not in IDLE.
- **Forwarding:** `fwd_valid = issue_valid && !hazard` and `issue_ready = fwd_ready && !hazard`. Both are combinational. `fwd_valid` does not depend on `fwd_ready`.
- **Drain FSM:**
  - IDLE → DRAIN when `drain_req` = 1.
  - DRAIN → DONE when all `cnt` = 0.
  - DONE → IDLE when `drain_req` = 0.
  - DRAIN → IDLE when `drain_req` drops before completion.
  - `drain_ack` = (state == DONE).
  - Retires continue to be processed in every state.

## Timing
- Zero-cycle forwarding path: no pipeline register between `issue_*` and `fwd_*`.
- Counter update is visible on the next cycle. A consumer stalled on register r issues no earlier than the cycle after r's last retire.
- `drain_ack` rises no earlier than the cycle after the counts reach zero. If counts are already zero, `drain_ack` is high 2 cycles after `drain_req` rises.
- Reset values: all `cnt` = 0, FSM = IDLE, `pend_mask` = 0, `busy` = 0, `drain_ack` = 0, `err` = 0. `fwd_valid` and `issue_ready` then follow their combinational equations.
- Reset mid-operation discards all tracking. Writebacks after reset for instructions issued before reset set `err`.
- The issuer keeps its payload stable while `issue_valid && !issue_ready`.

## Configuration
- `XADAC_VRF_SB_WAW_EN` defined:
  - The destination check becomes `cnt[issue_vd_addr]` ≠ 0. This enforces in-order writes per register.
  - The effective maximum per register is 1, so the `MaxPend` overflow rule never triggers.
- `XADAC_VRF_SB_WAW_EN` undefined:
  - Up to `MaxPend` outstanding writes per register.
  - The destination stalls only at overflow.

## Structure
- Add to `xadac_pkg`:
  - `SbStateT` enum {IDLE, DRAIN, DONE}.
  - `SbCntT` counter type.
- Sub-module `xadac_vrf_sb_cnt`: one saturating up/down counter per register with inc, dec, zero, full and underflow outputs. It is instantiated NoRegs times in a generate loop.

## Test plan
- **RAW stall/release:** issue write v3 (`fwd_ready` = 1), then read v3 → `fwd_valid` = 0 until the cycle after retire of v3, then `fwd_valid` = 1.
- **Overflow:** with the macro undefined and MaxPend = 3, issue four writes to v7 with no retire → the 4th is held (`issue_ready` = 0); one retire of v7 → the 4th issues the next cycle.
- **Simultaneous events:** `cnt[v5]` = 1, and the same cycle has an issue-write to v5 and a retire of v5 → `cnt[v5]` stays 1 and `pend_mask[5]` stays 1.
- **Drain:** two writes in flight plus `drain_req` → issue blocked and `drain_ack` = 0. After both retires, `drain_ack` = 1 on the following cycle. Dropping `drain_req` → IDLE, and issue resumes.
- **Underflow:** retire v9 with `cnt` = 0 → `err` = 1, `cnt[v9]` = 0, and `err` stays 1 until `rst`.
- **WAW build:** with the macro defined, issue write v2 and then a second write v2 → the second is held until v2 retires.
